// File: rtl/cpu_types_pkg.sv
// Shared datapath widths and encodings for the 5-stage pipeline.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [1:0] {
      M_IDLE,
      M_WAIT,
      M_HELD
   } memstate_t;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10,
      WB_LUI  = 2'b11
   } wbsel_t;

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer: one request per MEM instruction, held until dhit,
// with a load buffer for hits that land while the MEM/WB latch is frozen.
//
// state  | meaning
// M_IDLE | no access outstanding; a new access is requested immediately
// M_WAIT | request issued, waiting for dhit; address/data held by frozen EX/MEM
// M_HELD | access done while frozen; load data comes from the buffer, no request
module dmem_access_fsm
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  i_access,
   input  logic  i_dhit,
   input  logic  i_en_mw,
   input  word_t i_dmemload,
   output logic  o_req,
   output logic  o_mem_stall,
   output word_t o_load_data
);

   memstate_t r_state;
   word_t     r_buf;
   logic      w_req;

   // Gating with nRST drops an in-flight request the instant reset asserts.
   assign w_req       = nRST & i_access & (r_state != M_HELD);
   assign o_req       = w_req;
   assign o_mem_stall = w_req & ~i_dhit;
   assign o_load_data = (r_state == M_HELD) ? r_buf : i_dmemload;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= M_IDLE;
         r_buf   <= '0;
      end else begin
         case (r_state)
            M_IDLE, M_WAIT: begin
               if (i_access && i_dhit) begin
                  if (i_en_mw) begin
                     r_state <= M_IDLE;
                  end else begin
                     r_state <= M_HELD;
                     r_buf   <= i_dmemload;
                  end
               end else if (i_access) begin
                  r_state <= M_WAIT;
               end else begin
                  r_state <= M_IDLE;
               end
            end
            M_HELD: begin
               if (i_en_mw) r_state <= M_IDLE;
            end
            default: r_state <= M_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pipeline_memory_stage.sv
// MEM stage and MEM/WB latch: drives data-memory requests, selects writeback data
// and registers the WB-stage signals, including a halt that only reset clears.
module pipeline_memory_stage
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dREN_mem,
   input  logic        dWEN_mem,
   input  logic        RegWrite_mem,
   input  logic [1:0]  wsel_mem,
   input  logic        halt_mem,
   input  logic [31:0] port_o_mem,
   input  logic [31:0] rdat2_mem,
   input  logic [31:0] pc4_mem,
   input  logic [31:0] lui_mem,
   input  logic [4:0]  regWSEL_mem,
   input  logic        en_mw,
   input  logic        flush_mw,
   input  logic        dhit,
   input  logic [31:0] dmemload,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic [31:0] dmemaddr,
   output logic [31:0] dmemstore,
   output logic        mem_stall,
   output logic        RegWrite_wb,
   output logic [4:0]  regWSEL_wb,
   output logic [31:0] wdat_wb,
   output logic        halt_wb
);

   logic     r_regwrite_wb;
   regbits_t r_regwsel_wb;
   word_t    r_wdat_wb;
   logic     r_halt_wb;

   logic     w_access;
   logic     w_req;
   word_t    w_load_data;
   word_t    w_wdat;

   assign w_access = (dREN_mem | dWEN_mem) & ~r_halt_wb;

   dmem_access_fsm u_fsm (
      .CLK         (CLK),
      .nRST        (nRST),
      .i_access    (w_access),
      .i_dhit      (dhit),
      .i_en_mw     (en_mw),
      .i_dmemload  (dmemload),
      .o_req       (w_req),
      .o_mem_stall (mem_stall),
      .o_load_data (w_load_data)
   );

   assign dmemREN   = w_req & dREN_mem;
   assign dmemWEN   = w_req & dWEN_mem;
   assign dmemaddr  = port_o_mem;
   assign dmemstore = rdat2_mem;

   always_comb begin
      w_wdat = port_o_mem;
      case (wbsel_t'(wsel_mem))
         WB_ALU:  w_wdat = port_o_mem;
         WB_LOAD: w_wdat = w_load_data;
         WB_PC4:  w_wdat = pc4_mem;
         WB_LUI:  w_wdat = lui_mem;
         default: w_wdat = port_o_mem;
      endcase
   end

   // Flush bubbles the latch but never clears a halt that has already retired.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_regwrite_wb <= 1'b0;
         r_regwsel_wb  <= '0;
         r_wdat_wb     <= '0;
         r_halt_wb     <= 1'b0;
      end else if (en_mw) begin
         r_regwrite_wb <= RegWrite_mem & ~r_halt_wb;
         r_regwsel_wb  <= regWSEL_mem;
         r_wdat_wb     <= w_wdat;
         r_halt_wb     <= r_halt_wb | halt_mem;
      end else if (flush_mw) begin
         r_regwrite_wb <= 1'b0;
         r_regwsel_wb  <= '0;
         r_wdat_wb     <= '0;
      end
   end

   assign RegWrite_wb = r_regwrite_wb;
   assign regWSEL_wb  = r_regwsel_wb;
   assign wdat_wb     = r_wdat_wb;
   assign halt_wb     = r_halt_wb;

endmodule
